// File: rtl/key_conditioner_pkg.sv
// keycond_pkg: shared key FSM state type and parameter defaults for the key conditioner.
//   DEBOUNCE_CYCLES_DEF : stable synchronized samples needed to accept a level change
//   NKEYS_DEF           : number of pushbuttons conditioned
package keycond_pkg;
    typedef enum logic [2:0] {
        ARMING,
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } key_state_t;
    localparam int DEBOUNCE_CYCLES_DEF = 250000;
    localparam int NKEYS_DEF           = 4;
endpackage

// File: rtl/key_conditioner_if.sv
// key_conditioner_if: board-side inputs and calculator-side outputs of the key conditioner.
//   key_raw  : asynchronous pushbuttons, active-low
//   mode_raw : asynchronous mode switches
//   val_raw  : asynchronous operand switches
//   key      : one-hot single-cycle press strobes
//   mode/val : switch values captured with the most recent strobe
//   busy     : some key is not idle
//   master drives the raw inputs, slave is the conditioner
interface key_conditioner_if
    import keycond_pkg::*;
#(
    parameter int NKEYS = NKEYS_DEF
);
    logic [NKEYS-1:0] key_raw;
    logic [1:0]       mode_raw;
    logic [15:0]      val_raw;
    logic [NKEYS-1:0] key;
    logic [1:0]       mode;
    logic [15:0]      val;
    logic             busy;
    modport master (output key_raw, mode_raw, val_raw, input key, mode, val, busy);
    modport slave  (input key_raw, mode_raw, val_raw, output key, mode, val, busy);
endinterface

// File: rtl/key_conditioner_debounce.sv
// key_debounce: one pushbutton's synchronizer, saturating debounce counter and press FSM.
//   clk       : system clock
//   rst       : synchronous active-low reset
//   i_key_raw : asynchronous pushbutton, active-low
//   o_req     : press accepted this cycle (single cycle, on the edge entering HELD)
//   o_busy    : FSM is anywhere but IDLE
module key_debounce
    import keycond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic i_key_raw,
    output logic o_req,
    output logic o_busy
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [1:0]    r_sync;
    logic [CW-1:0] r_cnt;
    key_state_t    r_state;
    logic          w_pressed;
    logic          w_done;
    logic [CW-1:0] w_cnt_inc;
    assign w_pressed = ~r_sync[1];
    // The current sample is the DEBOUNCE_CYCLES-th consecutive one when the count already holds one less.
    assign w_done    = r_cnt == CW'(DEBOUNCE_CYCLES - 1);
    assign w_cnt_inc = (r_cnt == CW'(DEBOUNCE_CYCLES)) ? r_cnt : r_cnt + 1'b1;
    assign o_req     = (r_state == PRESS_WAIT) && w_pressed && w_done;
    assign o_busy    = r_state != IDLE;
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync  <= 2'b11;
            r_cnt   <= '0;
            r_state <= ARMING;
        end else begin
            r_sync <= {r_sync[0], i_key_raw};
            case (r_state)
                ARMING: begin
                    r_cnt   <= (w_pressed || w_done) ? '0 : w_cnt_inc;
                    r_state <= (!w_pressed && w_done) ? IDLE : ARMING;
                end
                IDLE: begin
                    r_cnt   <= '0;
                    r_state <= w_pressed ? PRESS_WAIT : IDLE;
                end
                PRESS_WAIT: begin
                    r_cnt   <= (!w_pressed || w_done) ? '0 : w_cnt_inc;
                    r_state <= !w_pressed ? IDLE : (w_done ? HELD : PRESS_WAIT);
                end
                HELD: begin
                    r_cnt   <= '0;
                    r_state <= w_pressed ? HELD : RELEASE_WAIT;
                end
                RELEASE_WAIT: begin
                    r_cnt   <= (w_pressed || w_done) ? '0 : w_cnt_inc;
                    r_state <= w_pressed ? HELD : (w_done ? IDLE : RELEASE_WAIT);
                end
                default: begin
                    r_cnt   <= '0;
                    r_state <= ARMING;
                end
            endcase
        end
    end
endmodule

// File: rtl/key_conditioner.sv
// key_conditioner: debounces NKEYS pushbuttons into one-hot press strobes with captured mode/operand switches.
//   clk : system clock
//   rst : synchronous active-low reset
//   bus : key_raw/mode_raw/val_raw in, key/mode/val/busy out (slave side)
module key_conditioner
    import keycond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int NKEYS           = NKEYS_DEF
) (
    input  logic                clk,
    input  logic                rst,
    key_conditioner_if.slave    bus
);
    logic [NKEYS-1:0] w_req;
    logic [NKEYS-1:0] w_busy;
    logic [NKEYS-1:0] w_all;
    logic [NKEYS-1:0] w_grant;
    logic [NKEYS-1:0] r_pend;
    logic [NKEYS-1:0] r_key;
    logic [1:0]       r_mode_s1, r_mode_s2, r_mode;
    logic [15:0]      r_val_s1, r_val_s2, r_val;
    for (genvar i = 0; i < NKEYS; i++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk      (clk),
            .rst      (rst),
            .i_key_raw(bus.key_raw[i]),
            .o_req    (w_req[i]),
            .o_busy   (w_busy[i])
        );
    end
    // New requests join the pending set in the same cycle; the lowest set bit wins, the rest wait.
    assign w_all   = r_pend | w_req;
    assign w_grant = w_all & (~w_all + NKEYS'(1));
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_mode_s1 <= '0;
            r_mode_s2 <= '0;
            r_val_s1  <= '0;
            r_val_s2  <= '0;
            r_pend    <= '0;
            r_key     <= '0;
            r_mode    <= '0;
            r_val     <= '0;
        end else begin
            r_mode_s1 <= bus.mode_raw;
            r_mode_s2 <= r_mode_s1;
            r_val_s1  <= bus.val_raw;
            r_val_s2  <= r_val_s1;
            r_pend    <= w_all & ~w_grant;
            r_key     <= w_grant;
            if (|w_grant) begin
                r_mode <= r_mode_s2;
                r_val  <= r_val_s2;
            end
        end
    end
    assign bus.key  = r_key;
    assign bus.mode = r_mode;
    assign bus.val  = r_val;
    assign bus.busy = |w_busy;
endmodule

// File: tb/tb_key_conditioner.sv
// tb_key_conditioner: scoreboard bench for key_conditioner with DEBOUNCE_CYCLES=4.
module tb_key_conditioner;
    localparam int D   = 4;
    localparam int LAT = 2 + D + 1;
    typedef struct {
        logic [3:0]  key;
        logic [1:0]  mode;
        logic [15:0] val;
        int          cyc;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    logic mon_en = 1'b0;
    exp_t exp_q[$];
    exp_t e;
    key_conditioner_if #(.NKEYS(4)) bus ();
    key_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .NKEYS          (4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic push(input logic [3:0] k, input logic [1:0] m, input logic [15:0] v, input int lat);
        exp_q.push_back('{k, m, v, cyc + lat});
    endtask
    // Every nonzero strobe must match the oldest expected entry, including its cycle.
    always @(negedge clk) begin
        if (mon_en && bus.key !== 4'b0) begin
            check("onehot", 32'($countones(bus.key)), 32'd1);
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", 32'(bus.key), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("key", 32'(bus.key), 32'(e.key));
                check("mode", 32'(bus.mode), 32'(e.mode));
                check("val", 32'(bus.val), 32'(e.val));
                check("cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end
    initial begin
        bus.key_raw  = 4'hF;
        bus.mode_raw = 2'b00;
        bus.val_raw  = 16'h0000;
        tick(3);
        mon_en = 1'b1;
        check("rst_key", 32'(bus.key), 32'd0);
        check("rst_mode", 32'(bus.mode), 32'd0);
        check("rst_val", 32'(bus.val), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        tick(2);
        check("arming_busy", 32'(bus.busy), 32'd1);
        tick(4);
        check("armed_busy", 32'(bus.busy), 32'd0);
        check("armed_key", 32'(bus.key), 32'd0);
        // clean press of key 2, held 50 cycles
        bus.mode_raw = 2'b10;
        bus.val_raw  = 16'hABCD;
        tick(3);
        push(4'b0100, 2'b10, 16'hABCD, LAT);
        bus.key_raw = 4'b1011;
        tick(LAT + 50);
        check("held_busy", 32'(bus.busy), 32'd1);
        bus.key_raw = 4'hF;
        tick(10);
        check("released_busy", 32'(bus.busy), 32'd0);
        check("q_after_press", 32'(exp_q.size()), 32'd0);
        // switch changes without a strobe must not move mode/val
        bus.mode_raw = 2'b11;
        bus.val_raw  = 16'hFFFF;
        tick(5);
        check("hold_mode", 32'(bus.mode), 32'd2);
        check("hold_val", 32'(bus.val), 32'hABCD);
        // bounce on key 0: low 3, high 1, low 3, then released
        bus.key_raw = 4'b1110;
        tick(3);
        bus.key_raw = 4'hF;
        tick(1);
        bus.key_raw = 4'b1110;
        tick(3);
        bus.key_raw = 4'hF;
        tick(10);
        check("bounce_none", 32'(exp_q.size()), 32'd0);
        check("bounce_busy", 32'(bus.busy), 32'd0);
        push(4'b0001, 2'b11, 16'hFFFF, LAT);
        bus.key_raw = 4'b1110;
        tick(LAT + 20);
        bus.key_raw = 4'hF;
        tick(10);
        check("q_after_bounce", 32'(exp_q.size()), 32'd0);
        // keys 1 and 3 on the same edge
        bus.mode_raw = 2'b01;
        bus.val_raw  = 16'h1234;
        tick(3);
        push(4'b0010, 2'b01, 16'h1234, LAT);
        push(4'b1000, 2'b01, 16'h1234, LAT + 1);
        bus.key_raw = 4'b0101;
        tick(LAT + 10);
        bus.key_raw = 4'hF;
        tick(10);
        check("q_after_simul", 32'(exp_q.size()), 32'd0);
        // key 0 held across reset release
        rst = 1'b0;
        bus.key_raw = 4'b1110;
        tick(3);
        check("rst2_mode", 32'(bus.mode), 32'd0);
        check("rst2_val", 32'(bus.val), 32'd0);
        rst = 1'b1;
        tick(20);
        check("held_rst_busy", 32'(bus.busy), 32'd1);
        bus.key_raw = 4'hF;
        tick(8);
        check("rearmed_busy", 32'(bus.busy), 32'd0);
        push(4'b0001, 2'b01, 16'h1234, LAT);
        bus.key_raw = 4'b1110;
        tick(LAT + 5);
        bus.key_raw = 4'hF;
        tick(10);
        check("q_after_held_rst", 32'(exp_q.size()), 32'd0);
        // reset two cycles into PRESS_WAIT
        bus.key_raw = 4'b0111;
        tick(5);
        rst = 1'b0;
        bus.key_raw = 4'hF;
        tick(2);
        check("mid_rst_busy", 32'(bus.busy), 32'd1);
        check("mid_rst_key", 32'(bus.key), 32'd0);
        rst = 1'b1;
        tick(4);
        check("mid_rst_rearm", 32'(bus.busy), 32'd0);
        tick(10);
        check("q_after_mid_rst", 32'(exp_q.size()), 32'd0);
        // reset while key 2's request is still pending behind key 1
        push(4'b0010, 2'b01, 16'h1234, LAT);
        bus.key_raw = 4'b1001;
        tick(LAT);
        rst = 1'b0;
        bus.key_raw = 4'hF;
        tick(1);
        check("pend_drop_key", 32'(bus.key), 32'd0);
        check("pend_drop_val", 32'(bus.val), 32'd0);
        tick(1);
        rst = 1'b1;
        tick(15);
        check("pend_drop_busy", 32'(bus.busy), 32'd0);
        check("q_final", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/key_conditioner.md
KEY_CONDITIONER -- requirements
Module: key_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 250000, consecutive stable synchronized samples (5 ms at 50 MHz) required to accept a level change.
REQ-002 Parameter NKEYS, default 4, number of pushbuttons conditioned.
REQ-003 clk  input  1  single system clock; all state SHALL update on its rising edge only.
REQ-004 rst  input  1  reset; synchronous, active-low (rst=0 sampled at a rising clk edge resets the block).
REQ-005 key_raw  input  NKEYS  asynchronous board pushbuttons, active-low (0 = pressed).
REQ-006 mode_raw  input  2  asynchronous mode switches.
REQ-007 val_raw  input  16  asynchronous operand switches.
REQ-008 key  output  NKEYS  one-hot, one-cycle, active-high press strobes to the RPN calculator.
REQ-009 mode  output  2  mode captured with the most recent strobe.
REQ-010 val  output  16  operand captured with the most recent strobe.
REQ-011 busy  output  1  high while any key is not in state IDLE.

Function
REQ-012 key_raw, mode_raw and val_raw SHALL each pass through a two-flop synchronizer before any other use.
REQ-013 Each key SHALL run an independent FSM: ARMING, IDLE, PRESS_WAIT, HELD, RELEASE_WAIT.
REQ-014 ARMING: count consecutive released samples; at DEBOUNCE_CYCLES go to IDLE; a pressed sample clears the count.
REQ-015 IDLE: pressed sample -> PRESS_WAIT with count cleared.
REQ-016 PRESS_WAIT: count consecutive pressed samples; a released sample returns to IDLE; at DEBOUNCE_CYCLES go to HELD and raise a press request.
REQ-017 HELD: released sample -> RELEASE_WAIT; holding indefinitely SHALL produce no further requests.
REQ-018 RELEASE_WAIT: count consecutive released samples; a pressed sample returns to HELD without a new request; at DEBOUNCE_CYCLES go to IDLE.
REQ-019 Releases SHALL never generate strobes.
REQ-020 Debounce counters SHALL be $clog2(DEBOUNCE_CYCLES+1) bits wide, saturate, and never wrap.
REQ-021 Latency: strobe SHALL assert exactly 2 + DEBOUNCE_CYCLES + 1 cycles after key_raw falls cleanly, measured from a key in IDLE.
REQ-022 At most one bit of key SHALL be high in any cycle.
REQ-023 Simultaneous requests: lowest index strobes first; the others remain pending and strobe on successive cycles in ascending index order; a pending request is never dropped.
REQ-024 In the strobe cycle, mode and val SHALL present the synchronized switch values sampled on the same edge that issued the strobe; otherwise they hold.
REQ-025 Switch changes with no strobe SHALL not change mode or val.

Reset
REQ-026 On rst=0: key=0, mode=0, val=0, busy=1, all counters=0, pending requests cleared, synchronizer flops=released/0, every key FSM=ARMING.
REQ-027 A key held through reset SHALL be ignored until released for DEBOUNCE_CYCLES, then pressed again.
REQ-028 Reset asserted mid-debounce or while a request is pending SHALL discard that press with no strobe.

Structure
REQ-029 Package keycond_pkg SHALL hold the key FSM state enum, the NKEYS default, and the DEBOUNCE_CYCLES default.
REQ-030 Sub-module key_debounce SHALL implement one key's synchronizer, counter and FSM.
REQ-031 key_conditioner SHALL instantiate NKEYS copies of key_debounce in a generate loop, plus the arbiter and switch capture.

Verification (DEBOUNCE_CYCLES=4)
REQ-032 Reset, key_raw=4'hF held 6 cycles -> key=0, busy falls after arming; mode=0, val=0.
REQ-033 Clean press of key_raw[2] -> key=4'b0100 for exactly one cycle, 7 cycles after the falling edge; holding 50 cycles -> no second strobe.
REQ-034 Bounce key_raw[0] low 3 cycles, high 1, low 3 cycles -> no strobe; then held low -> exactly one strobe.
REQ-035 key_raw[1] and key_raw[3] fall on the same edge, val_raw=16'h1234, mode_raw=2'b01 -> key=4'b0010, then 4'b1000 next cycle; val=16'h1234, mode=2'b01 on both.
REQ-036 key_raw[0] held low across reset release -> no strobe until released 4+ cycles and re-pressed.
REQ-037 Reset asserted 2 cycles into PRESS_WAIT, key_raw released before rst=1 -> no strobe; counters, FSM, busy back to reset values.
